// File: rtl/misr_sig_engine.sv
// Galois multiple-input signature register with BIST run control.
// Counts a programmed number of vectors, then compares against golden.
module misr_sig_engine #(
  parameter int             W     = 3,
  parameter logic [W-1:0]   POLY  = 3'b011,
  parameter logic [W-1:0]   SEED  = '0,
  parameter int             CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic [W-1:0]     golden,
  output logic [W-1:0]     signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [W-1:0]     r_sig;
  logic [W-1:0]     w_sig_nx;
  logic [W-1:0]     w_step;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len_nx;
  logic             r_pass;
  logic             w_pass_nx;
  logic             w_last;

  // Bit 0 always takes the feedback since POLY[0] is fixed at 1.
  always_comb begin
    w_step[0] = r_sig[W-1] ^ din[0];
    for (int i = 1; i < W; i++) begin
      w_step[i] = r_sig[i-1]
                ^ (POLY[i] & r_sig[W-1])
                ^ din[i];
    end
  end

  assign w_last = (r_cnt == r_len - ONE);

  always_comb begin
    w_state_nx = r_state;
    w_sig_nx   = r_sig;
    w_cnt_nx   = r_cnt;
    w_len_nx   = r_len;
    w_pass_nx  = r_pass;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_sig_nx  = SEED;
          w_cnt_nx  = '0;
          w_len_nx  = len;
          w_pass_nx = 1'b0;
          if (len == '0) begin
            w_state_nx = S_DONE;
            w_pass_nx  = (golden == SEED);
          end else begin
            w_state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (din_valid) begin
          w_sig_nx = w_step;
          w_cnt_nx = r_cnt + ONE;
          // Compare the post-step signature, not the current one.
          if (w_last) begin
            w_state_nx = S_DONE;
            w_pass_nx  = (w_step == golden);
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_len   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sig   <= w_sig_nx;
      r_cnt   <= w_cnt_nx;
      r_len   <= w_len_nx;
      r_pass  <= w_pass_nx;
    end
  end

  assign signature = r_sig;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;

endmodule

// File: tb/tb_misr_sig_engine.sv
// Self-checking bench for misr_sig_engine.
// Reference model: polynomial multiply-by-x modulo P(x), plus input add.
module tb_misr_sig_engine;

  localparam int           W     = 3;
  localparam logic [W-1:0] POLY  = 3'b011;
  localparam logic [W-1:0] SEED  = 3'b000;
  localparam int           CNT_W = 8;

  logic             CLK;
  logic             RST_N;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [W-1:0]     din;
  logic             din_valid;
  logic [W-1:0]     golden;
  logic [W-1:0]     signature;
  logic             busy;
  logic             done;
  logic             pass;

  int total;
  int bad;

  misr_sig_engine #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED),
    .CNT_W(CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .len      (len),
    .din      (din),
    .din_valid(din_valid),
    .golden   (golden),
    .signature(signature),
    .busy     (busy),
    .done     (done),
    .pass     (pass)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // s*x mod P(x) + d, P(x) = x^W + POLY
  function automatic logic [W-1:0] mstep(
    input logic [W-1:0] s,
    input logic [W-1:0] d
  );
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ {1'b1, POLY};
    return t[W-1:0] ^ d;
  endfunction

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    start = 0; len = 0; din = 0;
    din_valid = 0; golden = 0;
    @(negedge CLK);
    total++;
    if (signature !== SEED || busy !== 0 ||
        done !== 0 || pass !== 0) begin
      bad++;
      $display("FAIL reset got=%0h/%b%b%b exp=%0h/000",
               signature, busy, done, pass, SEED);
    end
    RST_N = 1'b1;
    tick;
    total++;
    if (signature !== SEED || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_rel got=%0h/%b%b exp=%0h/00",
               signature, busy, done, SEED);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] exp_s [4];
    exp_s[0] = 3'b001; exp_s[1] = 3'b010;
    exp_s[2] = 3'b100; exp_s[3] = 3'b011;
    golden = 3'b011;
    start = 1; len = 4;
    tick;
    start = 0;
    for (int k = 0; k < 4; k++) begin
      din_valid = 1;
      din = (k == 0) ? 3'b001 : 3'b000;
      tick;
      total++;
      if (signature !== exp_s[k]) begin
        bad++;
        $display("FAIL basic_sig%0d got=%0h exp=%0h",
                 k, signature, exp_s[k]);
      end
      total++;
      if (busy !== (k < 3) || done !== (k == 3)) begin
        bad++;
        $display("FAIL basic_flags%0d got=%b%b exp=%b%b",
                 k, busy, done, k < 3, k == 3);
      end
    end
    din_valid = 0;
    total++;
    if (pass !== 1'b1) begin
      bad++;
      $display("FAIL basic_pass got=%b exp=1", pass);
    end
  endtask

  // Back-to-back restart from DONE with a wrong golden.
  task automatic test_back_to_back;
    golden = 3'b010;
    start = 1; len = 4;
    tick;
    start = 0;
    total++;
    if (busy !== 1 || done !== 0 || signature !== SEED) begin
      bad++;
      $display("FAIL b2b_start got=%b%b/%0h exp=10/%0h",
               busy, done, signature, SEED);
    end
    for (int k = 0; k < 4; k++) begin
      din_valid = 1;
      din = (k == 0) ? 3'b001 : 3'b000;
      tick;
    end
    din_valid = 0;
    total++;
    if (signature !== 3'b011 || done !== 1 || pass !== 0) begin
      bad++;
      $display("FAIL b2b_end got=%0h/%b/%b exp=3/1/0",
               signature, done, pass);
    end
  endtask

  task automatic test_gaps;
    golden = 3'b011;
    start = 1; len = 4;
    tick;
    start = 0;
    for (int c = 0; c < 8; c++) begin
      din_valid = (c == 0 || c == 3 || c == 4 || c == 7);
      din = (c == 0) ? 3'b001 : 3'($urandom);
      if (din_valid && c != 0) din = 3'b000;
      tick;
      total++;
      if (done !== (c == 7)) begin
        bad++;
        $display("FAIL gap_done%0d got=%b exp=%b",
                 c, done, c == 7);
      end
    end
    din_valid = 0;
    total++;
    if (signature !== 3'b011 || pass !== 1) begin
      bad++;
      $display("FAIL gap_end got=%0h/%b exp=3/1",
               signature, pass);
    end
  endtask

  task automatic test_len_zero;
    golden = SEED;
    start = 1; len = 0;
    tick;
    start = 0;
    total++;
    if (done !== 1 || busy !== 0 ||
        signature !== SEED || pass !== 1) begin
      bad++;
      $display("FAIL len0_match got=%b%b/%0h/%b exp=10/%0h/1",
               done, busy, signature, pass, SEED);
    end
    golden = 3'b101;
    start = 1; len = 0;
    tick;
    start = 0;
    total++;
    if (done !== 1 || pass !== 0) begin
      bad++;
      $display("FAIL len0_miss got=%b/%b exp=1/0", done, pass);
    end
  endtask

  task automatic test_ignore;
    logic [W-1:0] s;
    logic [W-1:0] held;
    held = signature;
    din_valid = 1; din = 3'b111;
    tick; tick;
    total++;
    if (signature !== held || done !== 1) begin
      bad++;
      $display("FAIL done_hold got=%0h/%b exp=%0h/1",
               signature, done, held);
    end
    din_valid = 0;
    golden = 3'b000;
    start = 1; len = 4;
    tick;
    start = 0;
    s = SEED;
    for (int k = 0; k < 4; k++) begin
      din_valid = 1;
      din = 3'($urandom);
      start = (k == 2);
      len = 1;
      s = mstep(s, din);
      tick;
      total++;
      if (signature !== s || busy !== (k < 3)) begin
        bad++;
        $display("FAIL ign_run%0d got=%0h/%b exp=%0h/%b",
                 k, signature, busy, s, k < 3);
      end
    end
    start = 0;
    din_valid = 0;
    total++;
    if (pass !== (s == 3'b000)) begin
      bad++;
      $display("FAIL ign_pass got=%b exp=%b", pass, s == 0);
    end
  endtask

  task automatic test_reset_midrun;
    start = 1; len = 4;
    tick;
    start = 0;
    for (int k = 0; k < 2; k++) begin
      din_valid = 1; din = 3'b101;
      tick;
    end
    RST_N = 0;
    #1;
    total++;
    if (signature !== SEED || busy !== 0 ||
        done !== 0 || pass !== 0) begin
      bad++;
      $display("FAIL rst_mid got=%0h/%b%b%b exp=%0h/000",
               signature, busy, done, pass, SEED);
    end
    din_valid = 1; din = 3'b111;
    @(negedge CLK);
    RST_N = 1;
    tick;
    total++;
    if (signature !== SEED || busy !== 0) begin
      bad++;
      $display("FAIL idle_valid got=%0h/%b exp=%0h/0",
               signature, busy, SEED);
    end
    din_valid = 0;
    test_basic;
  endtask

  task automatic test_max_len;
    logic [W-1:0] s;
    golden = 3'($urandom);
    start = 1; len = 8'hff;
    tick;
    start = 0;
    s = SEED;
    for (int k = 0; k < 255; k++) begin
      din_valid = 1;
      din = 3'($urandom);
      s = mstep(s, din);
      tick;
      if (k == 253) begin
        total++;
        if (done !== 0 || busy !== 1) begin
          bad++;
          $display("FAIL max_early got=%b%b exp=01", done, busy);
        end
      end
    end
    din_valid = 0;
    total++;
    if (signature !== s || done !== 1 ||
        pass !== (s == golden)) begin
      bad++;
      $display("FAIL max_end got=%0h/%b/%b exp=%0h/1/%b",
               signature, done, pass, s, s == golden);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 24; r++) begin
      logic [CNT_W-1:0] n;
      logic [W-1:0]     s;
      logic [W-1:0]     g_end;
      int               acc;
      int               cyc;
      n = (r % 7 == 0) ? 8'd0 : 8'($urandom_range(1, 15));
      golden = 3'($urandom);
      g_end = golden;
      start = 1; len = n;
      din_valid = 1'($urandom); din = 3'($urandom);
      tick;
      start = 0;
      s = SEED;
      total++;
      if (signature !== s) begin
        bad++;
        $display("FAIL rnd_seed%0d got=%0h exp=%0h",
                 r, signature, s);
      end
      acc = 0;
      cyc = 0;
      while (acc < int'(n) && cyc < 500) begin
        din_valid = 1'($urandom);
        din = 3'($urandom);
        golden = 3'($urandom);
        start = ($urandom_range(0, 3) == 0);
        len = 8'($urandom);
        if (din_valid) begin
          s = mstep(s, din);
          acc++;
          if (acc == int'(n)) g_end = golden;
        end
        tick;
        cyc++;
        total++;
        if (signature !== s ||
            done !== (acc == int'(n))) begin
          bad++;
          $display("FAIL rnd_step%0d got=%0h/%b exp=%0h/%b",
                   r, signature, done, s, acc == int'(n));
        end
      end
      start = 0;
      din_valid = 0;
      total++;
      if (cyc >= 500) begin
        bad++;
        $display("FAIL rnd_timeout%0d got=%0d exp<500", r, cyc);
      end
      total++;
      if (done !== 1 || busy !== 0 ||
          pass !== (s == g_end)) begin
        bad++;
        $display("FAIL rnd_end%0d got=%b%b/%b exp=10/%b",
                 r, done, busy, pass, s == g_end);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_gaps;
    test_len_zero;
    test_ignore;
    test_reset_midrun;
    test_max_len;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
